reg_file: RTL and testbench



---
 rtl/mips_pkg.sv | 23 ++
 rtl/reg_read_port.sv | 32 +++
 rtl/reg_file.sv | 65 ++++++
 tb/tb_reg_file.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared MIPS datapath constants: register-file geometry
// and ALU_control opcodes used by decoder and ALU alike.
package mips_pkg;

  localparam int REG_NUM    = 32;
  localparam int REG_W      = 32;
  localparam int REG_ADDR_W = 5;

  localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;
  localparam logic [REG_ADDR_W-1:0] REG_SP   = 5'd29;
  localparam logic [REG_W-1:0]      SP_RESET = 32'd128;

  typedef enum logic [3:0] {
    ALU_AND  = 4'b0000,
    ALU_OR   = 4'b0001,
    ALU_ADD  = 4'b0010,
    ALU_SUB  = 4'b0110,
    ALU_SLT  = 4'b0111,
    ALU_NOR  = 4'b1100,
    ALU_NAND = 4'b1101
  } alu_op_e;

endpackage

// File: rtl/reg_read_port.sv
// One combinational read port: forces address 0 to zero and optionally
// forwards same-cycle write data. Ports: addr, stored, byp_en, wr_addr, wr_data -> data.
module reg_read_port
  import mips_pkg::*;
#(
  parameter int DATA_W = REG_W,
  parameter int ADDR_W = REG_ADDR_W,
  parameter bit BYPASS = 1'b1
) (
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] stored,
  input  logic              byp_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic [DATA_W-1:0] data
);

  logic hit;

  // byp_en already excludes reset and writes to r0
  assign hit = BYPASS && byp_en && (wr_addr == addr);

  always_comb begin
    data = stored;
    unique case (1'b1)
      hit:           data = wr_data;
      (addr == '0):  data = '0;
      default:       data = stored;
    endcase
  end

endmodule

// File: rtl/reg_file.sv
// 32x32 MIPS register file: two combinational reads, one synchronous write.
// Ports: clk_i, rst_i, RSaddr_i, RTaddr_i, RDaddr_i, RDdata_i, RegWrite_i -> RSdata_o, RTdata_o.
module reg_file
  import mips_pkg::*;
#(
  parameter int                DATA_W  = REG_W,
  parameter int                ADDR_W  = REG_ADDR_W,
  parameter logic [DATA_W-1:0] SP_INIT = SP_RESET,
  parameter bit                BYPASS  = 1'b1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [ADDR_W-1:0] RSaddr_i,
  input  logic [ADDR_W-1:0] RTaddr_i,
  input  logic [ADDR_W-1:0] RDaddr_i,
  input  logic [DATA_W-1:0] RDdata_i,
  input  logic              RegWrite_i,
  output logic [DATA_W-1:0] RSdata_o,
  output logic [DATA_W-1:0] RTdata_o
);

  localparam int N = 1 << ADDR_W;

  logic [DATA_W-1:0] regs [N];
  logic              wr_en;

  assign wr_en = RegWrite_i && !rst_i && (RDaddr_i != '0);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < N; i++) begin
        regs[i] <= (i == int'(REG_SP)) ? SP_INIT : '0;
      end
    end else if (wr_en) begin
      regs[RDaddr_i] <= RDdata_i;
    end
  end

  reg_read_port #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .BYPASS (BYPASS)
  ) u_rs (
    .addr    (RSaddr_i),
    .stored  (regs[RSaddr_i]),
    .byp_en  (wr_en),
    .wr_addr (RDaddr_i),
    .wr_data (RDdata_i),
    .data    (RSdata_o)
  );

  reg_read_port #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .BYPASS (BYPASS)
  ) u_rt (
    .addr    (RTaddr_i),
    .stored  (regs[RTaddr_i]),
    .byp_en  (wr_en),
    .wr_addr (RDaddr_i),
    .wr_data (RDdata_i),
    .data    (RTdata_o)
  );

endmodule

// File: tb/tb_reg_file.sv
// Bench for reg_file: directed steps plus random traffic against an
// array reference model, on a BYPASS=1 and a BYPASS=0 instance.
module tb_reg_file;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  rs, rt, rd;
  logic [31:0] wd;
  logic        we;
  logic [31:0] rs1, rt1, rs0, rt0;

  int n_chk  = 0;
  int n_fail = 0;

  logic [31:0] model [32];

  always #5 clk = ~clk;

  reg_file #(.BYPASS(1'b1)) dut (
    .clk_i (clk), .rst_i (rst),
    .RSaddr_i (rs), .RTaddr_i (rt),
    .RDaddr_i (rd), .RDdata_i (wd),
    .RegWrite_i (we),
    .RSdata_o (rs1), .RTdata_o (rt1)
  );

  reg_file #(.BYPASS(1'b0)) dut_nb (
    .clk_i (clk), .rst_i (rst),
    .RSaddr_i (rs), .RTaddr_i (rt),
    .RDaddr_i (rd), .RDdata_i (wd),
    .RegWrite_i (we),
    .RSdata_o (rs0), .RTdata_o (rt0)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] expect_rd(input logic [4:0] a,
                                            input bit byp);
    if (a == 5'd0) return 32'h0;
    if (byp && we && !rst && rd == a) return wd;
    return model[a];
  endfunction

  function automatic void model_edge();
    if (rst) begin
      foreach (model[i]) model[i] = (i == 29) ? 32'd128 : 32'd0;
    end else if (we && rd != 5'd0) begin
      model[rd] = wd;
    end
  endfunction

  task automatic check_all(input string tag);
    chk({tag, "_rs_b1"}, rs1, expect_rd(rs, 1'b1));
    chk({tag, "_rt_b1"}, rt1, expect_rd(rt, 1'b1));
    chk({tag, "_rs_b0"}, rs0, expect_rd(rs, 1'b0));
    chk({tag, "_rt_b0"}, rt0, expect_rd(rt, 1'b0));
  endtask

  task automatic edge_step();
    @(posedge clk);
    model_edge();
    #2;
  endtask

  task automatic write(input logic [4:0] a, input logic [31:0] d);
    we = 1'b1; rd = a; wd = d;
    edge_step();
    we = 1'b0;
    #1;
  endtask

  initial begin
    rst = 1'b1; we = 1'b0;
    rs = '0; rt = '0; rd = '0; wd = '0;
    foreach (model[i]) model[i] = 32'hx;

    edge_step();
    edge_step();
    rst = 1'b0;
    #1;

    // reset sweep on both ports
    for (int a = 0; a < 32; a++) begin
      rs = 5'(a); rt = 5'(31 - a);
      #1;
      chk("rst_sweep_rs", rs1, (a == 29) ? 32'h80 : 32'h0);
      chk("rst_sweep_rt", rt1, (a == 2) ? 32'h80 : 32'h0);
      chk("rst_sweep_rs_nb", rs0, (a == 29) ? 32'h80 : 32'h0);
      chk("rst_sweep_rt_nb", rt0, (a == 2) ? 32'h80 : 32'h0);
    end

    // write/read-back and ALU add of the pair
    write(5'd8, 32'hDEADBEEF);
    write(5'd9, 32'h00000001);
    rs = 5'd8; rt = 5'd9;
    #1;
    chk("wb_r8", rs1, 32'hDEADBEEF);
    chk("wb_r9", rt1, 32'h00000001);
    chk("alu_add", rs1 + rt1, 32'hDEADBEF0);
    check_all("wb");

    // writes to r0 are dropped, even while in flight
    rs = 5'd0; rt = 5'd0;
    we = 1'b1; rd = 5'd0; wd = 32'hFFFFFFFF;
    #1;
    chk("r0_inflight_rs", rs1, 32'h0);
    chk("r0_inflight_rt", rt1, 32'h0);
    edge_step();
    we = 1'b0;
    #1;
    chk("r0_after_rs", rs1, 32'h0);
    chk("r0_after_rt", rt0, 32'h0);

    // same-cycle bypass vs stored value
    write(5'd5, 32'h11111111);
    rs = 5'd5; rt = 5'd5;
    we = 1'b1; rd = 5'd5; wd = 32'h22222222;
    #1;
    chk("byp1_rs", rs1, 32'h22222222);
    chk("byp1_rt", rt1, 32'h22222222);
    chk("byp0_rs", rs0, 32'h11111111);
    chk("byp0_rt", rt0, 32'h11111111);
    edge_step();
    we = 1'b0;
    #1;
    chk("byp0_after_rs", rs0, 32'h22222222);
    chk("byp0_after_rt", rt0, 32'h22222222);
    chk("byp1_after_rs", rs1, 32'h22222222);

    // write enable low holds r7
    we = 1'b0; rd = 5'd7; wd = 32'hA5A5A5A5;
    rs = 5'd7; rt = 5'd7;
    repeat (3) edge_step();
    chk("we_low_r7", rs1, 32'h0);
    chk("we_low_r7_nb", rt0, 32'h0);

    // reset beats a simultaneous write; no bypass under reset
    write(5'd29, 32'h00001000);
    rs = 5'd29;
    #1;
    chk("sp_written", rs1, 32'h00001000);
    rst = 1'b1; we = 1'b1; rd = 5'd10; wd = 32'h12345678;
    rs = 5'd10; rt = 5'd29;
    #1;
    chk("rst_nobyp_r10", rs1, 32'h0);
    chk("rst_nobyp_r29", rt1, 32'h00001000);
    edge_step();
    rst = 1'b0; we = 1'b0;
    #1;
    chk("coll_r10", rs1, 32'h0);
    chk("coll_r29", rt1, 32'h80);
    check_all("coll");

    // random traffic
    for (int k = 0; k < 300; k++) begin
      rst = ($urandom_range(0, 31) == 0);
      we  = $urandom_range(0, 3) != 0;
      rd  = 5'($urandom_range(0, 31));
      wd  = $urandom;
      rs  = ($urandom_range(0, 2) == 0) ? rd : 5'($urandom_range(0, 31));
      rt  = ($urandom_range(0, 2) == 0) ? rd : 5'($urandom_range(0, 31));
      #1;
      check_all("rand");
      edge_step();
    end

    // final sweep of stored contents
    rst = 1'b0; we = 1'b0;
    for (int a = 0; a < 32; a++) begin
      rs = 5'(a); rt = 5'(a);
      #1;
      check_all("final");
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
